vga_plot_ctrl: RTL and testbench
================================

Name: vga_plot_ctrl

Overview:
- Memory-mapped pixel-drawing engine between the processor's VGA I/O region (word_addr[15:12]==4'h4) and vga_adapter.
- CPU writes position, colour, size and command registers. The engine then drives the adapter's x/y/colour/plot with one pixel per cycle, for either a single pixel or a filled rectangle.
- Replaces loose per-field registers with a snapshotting command engine, clipped to the 800x600 mode.

Parameters:
- SCREEN_W, 800, pixels per line; x >= SCREEN_W is clipped.
- SCREEN_H, 600, lines; y >= SCREEN_H is clipped.
- COLOUR_W, 9, colour width (3 bits per channel).
- FIFO_DEPTH, 4, command queue depth, power of two; used only with VGA_PLOT_FIFO_EN.

Ports:
- clk  in  1  system clock (CLOCK_50).
- resetn  in  1  asynchronous active-low reset.
- cs  in  1  VGA region select.
- wr  in  1  processor write strobe (W).
- addr  in  2  word offset within region (word_addr[1:0]).
- wdata  in  32  processor write data.
- rdata  out  32  combinational read data.
- vga_x  out  16  pixel x to vga_adapter.
- vga_y  out  16  pixel y to vga_adapter.
- vga_colour  out  COLOUR_W  pixel colour to vga_adapter.
- vga_plot  out  1  pixel write strobe to vga_adapter.
- busy  out  1  engine or queue active.

Behaviour:
- Reset (async, resetn=0): immediately clears all registers, state=IDLE, vga_plot=0, vga_x/vga_y/vga_colour=0, busy=0, overrun=0, FIFO empty. Any in-flight rectangle is abandoned.
- Registers, written when cs&wr at the rising edge:
  - Offset 0 POS: [15:0] x0, [31:16] y0.
  - Offset 1 COLOUR: [COLOUR_W-1:0].
  - Offset 2 SIZE: [15:0] w, [31:16] h.
  - Offset 3 CMD: bit0 start, bit1 mode (0 pixel, 1 rect), bit2 clear overrun.
- Reads: offsets 0–2 return the stored values, zero-extended. Offset 3 returns {30'b0, overrun, busy}.
- Start snapshot: a start captures {x0, y0, w, h, colour, mode} into the command. Later register writes do not affect a running command.
- States:
  - IDLE: accepts a command.
  - DRAW: emits one pixel per cycle.
- IDLE transitions:
  - Mode 0: go to DRAW for exactly 1 pixel at (x0, y0).
  - Mode 1 with w==0 or h==0: no-op, stays IDLE, no plot pulse.
  - Mode 1 otherwise: cur_x=x0, cur_y=y0, go to DRAW.
- Latency: start sampled at edge N; first pixel on outputs after edge N+1 (registered outputs).
- DRAW pixel cycle: vga_x=cur_x[15:0], vga_y=cur_y[15:0], vga_colour=snapshot colour.
  - vga_plot=1 only if cur_x<SCREEN_W and cur_y<SCREEN_H.
  - Clipped pixels still consume their cycle.
- Scan order is raster, x fastest. cur_x/cur_y are 17-bit, and end_x=x0+w-1 / end_y=y0+h-1 are computed in 17 bits, so coordinates never wrap; values above 16 bits are clipped.
- Advance: if cur_x==end_x then cur_x=x0 and (cur_y==end_y ? return to IDLE : cur_y++); else cur_x++.
- Duration: a rectangle occupies exactly w*h DRAW cycles. vga_plot returns to 0 the cycle after the last pixel.
- busy = (state!=IDLE) | FIFO non-empty.
- Without FIFO:
  - Start while busy: command dropped, overrun set.
  - Start in the cycle DRAW ends: accepted (engine returns to IDLE and loads at the same edge).
- overrun is sticky; cleared by a CMD write with bit2=1. If set and clear occur in the same write, set wins.
- Non-cs or read cycles have no side effects.

Optional Feature:
- Macro VGA_PLOT_FIFO_EN.
- Defined:
  - Start snapshots are pushed into a FIFO_DEPTH command queue; the engine pops whenever it is IDLE or finishing its last pixel, giving back-to-back commands with no gap cycle.
  - Push when full is dropped and sets overrun, unless a pop occurs at the same edge.
  - Zero-size rect commands are popped and discarded in one cycle.
- Undefined: single command slot; behaviour as above.

Decomposition:
- Package vga_plot_pkg holds:
  - Register offsets: POS=0, COLOUR=1, SIZE=2, CMD=3.
  - CMD bit indices.
  - State enum {IDLE, DRAW}.
  - Packed command struct {x0, y0, w, h, colour, mode}.
- Sub-module vga_cmd_fifo: synchronous FIFO of the command struct, same clk/resetn; instantiated only under VGA_PLOT_FIFO_EN.

Test Plan:
- POS=(20<<16)|10, COLOUR=0x1C0, CMD=0x1 -> one vga_plot pulse at x=10, y=20, colour=0x1C0, one cycle after the write; busy high for 1 cycle.
- POS=(20<<16)|10, SIZE=(2<<16)|3, CMD=0x3 -> 6 consecutive pulses: (10,20),(11,20),(12,20),(10,21),(11,21),(12,21); then busy=0.
- POS=(599<<16)|798, SIZE=(2<<16)|4, CMD=0x3 -> busy for 8 cycles; pulses only at (798,599) and (799,599).
- SIZE=0x00050000 (w=0, h=5), CMD=0x3 -> no pulse, busy stays 0, status reads 0.
- No FIFO: start a 100-pixel rect, issue a second CMD=0x1 mid-draw -> ignored, status=0x3 while drawing; CMD=0x4 clears overrun.
  - With FIFO: 5 starts during one long rect -> 4 queued and executed in order, 5th sets overrun.
- Drop resetn in the middle of a 3x2 rect -> vga_plot=0 and busy=0 immediately; after release no further pulses; all registers read 0.

Source files
------------

// File: rtl/vga_plot_pkg.sv
// Shared definitions for the VGA pixel-plot engine: register map, CMD bits,
// engine state and the snapshotted command record.
package vga_plot_pkg;

  localparam logic [1:0] REG_POS    = 2'd0;
  localparam logic [1:0] REG_COLOUR = 2'd1;
  localparam logic [1:0] REG_SIZE   = 2'd2;
  localparam logic [1:0] REG_CMD    = 2'd3;

  localparam int CMD_START   = 0;
  localparam int CMD_MODE    = 1;
  localparam int CMD_CLR_OVR = 2;

  localparam int PLOT_COLOUR_W = 9;

  typedef enum logic {IDLE = 1'b0, DRAW = 1'b1} state_t;

  typedef struct packed {
    logic [15:0]              x0;
    logic [15:0]              y0;
    logic [15:0]              w;
    logic [15:0]              h;
    logic [PLOT_COLOUR_W-1:0] colour;
    logic                     mode;
  } plot_cmd_t;

  // Inclusive end coordinate; 17 bits so origin + length never wraps.
  function automatic logic [16:0] span_end(input logic [15:0] org, input logic [15:0] len);
    return {1'b0, org} + {1'b0, len} - 17'd1;
  endfunction

endpackage

// File: rtl/vga_cmd_fifo.sv
// Command queue for the plot engine; a push into a full queue is accepted
// only when a pop frees a slot at the same edge.
module vga_cmd_fifo
  import vga_plot_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      resetn,
  input  logic      push,
  input  plot_cmd_t din,
  input  logic      pop,
  output plot_cmd_t dout,
  output logic      full,
  output logic      empty
);

  localparam int AW = $clog2(DEPTH);

  plot_cmd_t      mem [DEPTH];
  logic [AW:0]    wptr;
  logic [AW:0]    rptr;
  logic           do_pop;
  logic           do_push;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rptr[AW-1:0]];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/vga_plot_ctrl.sv
// Memory-mapped pixel/rectangle plot engine driving vga_adapter, one pixel per
// cycle with clipping. Define VGA_PLOT_FIFO_EN to queue commands in vga_cmd_fifo.
module vga_plot_ctrl
  import vga_plot_pkg::*;
#(
  parameter int SCREEN_W   = 800,
  parameter int SCREEN_H   = 600,
  parameter int COLOUR_W   = PLOT_COLOUR_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                cs,
  input  logic                wr,
  input  logic [1:0]          addr,
  input  logic [31:0]         wdata,
  output logic [31:0]         rdata,
  output logic [15:0]         vga_x,
  output logic [15:0]         vga_y,
  output logic [COLOUR_W-1:0] vga_colour,
  output logic                vga_plot,
  output logic                busy
);

  logic [15:0]         pos_x, pos_y, size_w, size_h;
  logic [COLOUR_W-1:0] colour_reg;
  logic                overrun;
  state_t              state;
  logic [16:0]         cur_x, cur_y, end_x, end_y;
  logic [15:0]         org_x;
  logic [COLOUR_W-1:0] pix_colour;

  logic      wr_en, start, clr_ovr, last_px, engine_free;
  logic      load_vld, load_go, drop, queued;
  plot_cmd_t cmd_new, load_cmd;

  function automatic logic on_screen(input logic [16:0] px, input logic [16:0] py);
    return (px < 17'(SCREEN_W)) && (py < 17'(SCREEN_H));
  endfunction

  assign wr_en       = cs & wr;
  assign start       = wr_en && (addr == REG_CMD) && wdata[CMD_START];
  assign clr_ovr     = wr_en && (addr == REG_CMD) && wdata[CMD_CLR_OVR];
  assign last_px     = (state == DRAW) && (cur_x == end_x) && (cur_y == end_y);
  assign engine_free = (state == IDLE) || last_px;

  always_comb begin
    cmd_new        = '0;
    cmd_new.x0     = pos_x;
    cmd_new.y0     = pos_y;
    cmd_new.w      = size_w;
    cmd_new.h      = size_h;
    cmd_new.colour = PLOT_COLOUR_W'(colour_reg);
    cmd_new.mode   = wdata[CMD_MODE];
  end

`ifdef VGA_PLOT_FIFO_EN
  logic      fifo_full, fifo_empty, pop, push, bypass;
  plot_cmd_t fifo_head;

  // An empty queue with a free engine loads directly, keeping single-command latency.
  assign pop      = engine_free & ~fifo_empty;
  assign bypass   = engine_free & fifo_empty & start;
  assign push     = start & ~bypass;
  assign load_vld = pop | bypass;
  assign load_cmd = pop ? fifo_head : cmd_new;
  assign drop     = push & fifo_full & ~pop;
  assign queued   = ~fifo_empty;

  vga_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_cmd_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (push),
    .din    (cmd_new),
    .pop    (pop),
    .dout   (fifo_head),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );
`else
  assign load_vld = start & engine_free;
  assign load_cmd = cmd_new;
  assign drop     = start & ~engine_free;
  assign queued   = 1'b0;
`endif

  assign load_go = ~load_cmd.mode || ((load_cmd.w != 16'd0) && (load_cmd.h != 16'd0));
  assign busy    = (state != IDLE) | queued;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pos_x      <= '0;
      pos_y      <= '0;
      size_w     <= '0;
      size_h     <= '0;
      colour_reg <= '0;
      overrun    <= 1'b0;
    end else begin
      if (wr_en && addr == REG_POS)    {pos_y, pos_x}   <= wdata;
      if (wr_en && addr == REG_COLOUR) colour_reg       <= wdata[COLOUR_W-1:0];
      if (wr_en && addr == REG_SIZE)   {size_h, size_w} <= wdata;
      if (drop)         overrun <= 1'b1;
      else if (clr_ovr) overrun <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      cur_x      <= '0;
      cur_y      <= '0;
      end_x      <= '0;
      end_y      <= '0;
      org_x      <= '0;
      pix_colour <= '0;
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
      vga_plot   <= 1'b0;
    end else begin
      // Output stage: present the current scan position one cycle after it is reached.
      vga_plot <= 1'b0;
      if (state == DRAW) begin
        vga_x      <= cur_x[15:0];
        vga_y      <= cur_y[15:0];
        vga_colour <= pix_colour;
        vga_plot   <= on_screen(cur_x, cur_y);
      end
      // Scan stage: a new command overrides the advance on the final pixel.
      if (load_vld && load_go) begin
        state      <= DRAW;
        cur_x      <= {1'b0, load_cmd.x0};
        cur_y      <= {1'b0, load_cmd.y0};
        org_x      <= load_cmd.x0;
        pix_colour <= COLOUR_W'(load_cmd.colour);
        end_x      <= load_cmd.mode ? span_end(load_cmd.x0, load_cmd.w) : {1'b0, load_cmd.x0};
        end_y      <= load_cmd.mode ? span_end(load_cmd.y0, load_cmd.h) : {1'b0, load_cmd.y0};
      end else if (state == DRAW) begin
        if (cur_x == end_x) begin
          cur_x <= {1'b0, org_x};
          if (cur_y == end_y) state <= IDLE;
          else                cur_y <= cur_y + 17'd1;
        end else begin
          cur_x <= cur_x + 17'd1;
        end
      end
    end
  end

  always_comb begin
    rdata = '0;
    case (addr)
      REG_POS:    rdata = {pos_y, pos_x};
      REG_COLOUR: rdata = 32'(colour_reg);
      REG_SIZE:   rdata = {size_h, size_w};
      default:    rdata = {30'd0, overrun, busy};
    endcase
  end

endmodule

// File: tb/tb_vga_plot_ctrl.sv
// Directed bench for vga_plot_ctrl (default build): register access, pixel and
// rectangle drawing, clipping, zero-size, overrun handling and async reset.
module tb_vga_plot_ctrl;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        cs = 1'b0;
  logic        wr = 1'b0;
  logic [1:0]  addr = 2'd0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] rdata;
  logic [15:0] vga_x, vga_y;
  logic [8:0]  vga_colour;
  logic        vga_plot, busy;

  int n_checks = 0;
  int n_fail = 0;

  typedef struct {int cyc; int x; int y; int c;} pix_t;
  pix_t pix_q[$];
  int   cyc_cnt = 0;
  int   busy_cnt = 0;

  vga_plot_ctrl dut (
    .clk        (clk),
    .resetn     (resetn),
    .cs         (cs),
    .wr         (wr),
    .addr       (addr),
    .wdata      (wdata),
    .rdata      (rdata),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Pixel/busy logger, sampling 2 time units after each rising edge.
  always @(posedge clk) begin
    pix_t p;
    #2;
    cyc_cnt++;
    if (busy) busy_cnt++;
    if (vga_plot) begin
      p.cyc = cyc_cnt; p.x = vga_x; p.y = vga_y; p.c = vga_colour;
      pix_q.push_back(p);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
    cs = 1'b1; wr = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    cs = 1'b0; wr = 1'b0;
  endtask

  task automatic rd_reg(input logic [1:0] a, output logic [31:0] d);
    addr = a;
    #1;
    d = rdata;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", {31'd0, busy}, 32'd0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    logic [31:0] d;
    int base, b0, c0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_plot", {31'd0, vga_plot}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_xy", {vga_y, vga_x}, 0);
    resetn = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rd_reg(2'(i), d);
      check($sformatf("rst_reg%0d", i), d, 0);
    end

    // Register readback, non-cs write ignored
    wr_reg(2'd1, 32'hFFFF_FFFF);
    rd_reg(2'd1, d);
    check("colour_rb", d, 32'h1FF);
    wr_reg(2'd2, 32'hDEAD_BEEF);
    rd_reg(2'd2, d);
    check("size_rb", d, 32'hDEAD_BEEF);
    cs = 1'b0; wr = 1'b1; addr = 2'd2; wdata = 32'h1234_5678;
    @(negedge clk);
    wr = 1'b0;
    rd_reg(2'd2, d);
    check("no_cs_write", d, 32'hDEAD_BEEF);

    // Single pixel
    wr_reg(2'd0, (20 << 16) | 10);
    wr_reg(2'd1, 32'h1C0);
    base = pix_q.size(); b0 = busy_cnt;
    wr_reg(2'd3, 32'h1);
    c0 = cyc_cnt;
    repeat (4) @(negedge clk);
    check("px_count", pix_q.size() - base, 1);
    if (pix_q.size() > base) begin
      check("px_lat", pix_q[base].cyc, c0 + 1);
      check("px_xy", {pix_q[base].y[15:0], pix_q[base].x[15:0]}, {16'd20, 16'd10});
      check("px_colour", pix_q[base].c, 32'h1C0);
    end
    check("px_busy", busy_cnt - b0, 1);

    // 3x2 rectangle in raster order
    wr_reg(2'd2, (2 << 16) | 3);
    base = pix_q.size(); b0 = busy_cnt;
    wr_reg(2'd3, 32'h3);
    c0 = cyc_cnt;
    wait_idle(50);
    check("rect_count", pix_q.size() - base, 6);
    for (int i = 0; i < 6 && base + i < pix_q.size(); i++) begin
      check($sformatf("rect_xy%0d", i), {pix_q[base+i].y[15:0], pix_q[base+i].x[15:0]},
            {16'(20 + i / 3), 16'(10 + i % 3)});
      check($sformatf("rect_cyc%0d", i), pix_q[base+i].cyc, c0 + 1 + i);
    end
    check("rect_busy", busy_cnt - b0, 6);

    // Clipping at the bottom-right corner
    wr_reg(2'd0, (599 << 16) | 798);
    wr_reg(2'd2, (2 << 16) | 4);
    base = pix_q.size(); b0 = busy_cnt;
    wr_reg(2'd3, 32'h3);
    wait_idle(50);
    check("clip_busy", busy_cnt - b0, 8);
    check("clip_count", pix_q.size() - base, 2);
    if (pix_q.size() >= base + 2) begin
      check("clip_px0", {pix_q[base].y[15:0], pix_q[base].x[15:0]}, {16'd599, 16'd798});
      check("clip_px1", {pix_q[base+1].y[15:0], pix_q[base+1].x[15:0]}, {16'd599, 16'd799});
    end

    // Zero-width rectangle is a no-op
    wr_reg(2'd2, 32'h0005_0000);
    base = pix_q.size(); b0 = busy_cnt;
    wr_reg(2'd3, 32'h3);
    check("zero_busy_now", {31'd0, busy}, 0);
    rd_reg(2'd3, d);
    check("zero_status", d, 0);
    repeat (4) @(negedge clk);
    check("zero_count", pix_q.size() - base, 0);
    check("zero_busy", busy_cnt - b0, 0);

    // Start on the final pixel cycle is accepted
    wr_reg(2'd0, (5 << 16) | 7);
    base = pix_q.size();
    wr_reg(2'd3, 32'h1);
    wr_reg(2'd3, 32'h1);
    repeat (4) @(negedge clk);
    check("b2b_count", pix_q.size() - base, 2);
    if (pix_q.size() >= base + 2)
      check("b2b_gap", pix_q[base+1].cyc - pix_q[base].cyc, 1);
    rd_reg(2'd3, d);
    check("b2b_status", d, 0);

    // Start while busy is dropped and sets overrun
    wr_reg(2'd0, 32'h0);
    wr_reg(2'd2, (10 << 16) | 10);
    base = pix_q.size(); b0 = busy_cnt;
    wr_reg(2'd3, 32'h3);
    repeat (10) @(negedge clk);
    wr_reg(2'd3, 32'h1);
    rd_reg(2'd3, d);
    check("ovr_status_busy", d, 32'h3);
    wait_idle(300);
    check("ovr_count", pix_q.size() - base, 100);
    if (pix_q.size() >= base + 100)
      check("ovr_last", {pix_q[base+99].y[15:0], pix_q[base+99].x[15:0]}, {16'd9, 16'd9});
    check("ovr_busy", busy_cnt - b0, 100);
    rd_reg(2'd3, d);
    check("ovr_sticky", d, 32'h2);
    wr_reg(2'd3, 32'h4);
    rd_reg(2'd3, d);
    check("ovr_clear", d, 0);

    // Set beats clear, then reset mid-rectangle
    wr_reg(2'd0, (20 << 16) | 10);
    wr_reg(2'd2, (2 << 16) | 3);
    wr_reg(2'd3, 32'h3);
    wr_reg(2'd3, 32'h5);
    rd_reg(2'd3, d);
    check("set_wins", d, 32'h3);
    resetn = 1'b0;
    #1;
    check("rst_mid_plot", {31'd0, vga_plot}, 0);
    check("rst_mid_busy", {31'd0, busy}, 0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    base = pix_q.size();
    repeat (10) @(negedge clk);
    check("rst_no_pulse", pix_q.size() - base, 0);
    for (int i = 0; i < 4; i++) begin
      rd_reg(2'(i), d);
      check($sformatf("rst_mid_reg%0d", i), d, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
